// File: rtl/pad_pkg.sv
// Shared definitions for the multi-pad controller poller: FSM state encoding and default timing.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pad_pkg;

  // Default timing for a 50 MHz core polling at 60 Hz
  localparam int POLL_PERIOD_60HZ  = 833333;
  localparam int LATCH_CYCLES_DEF  = 600;
  localparam int HALF_PULSE_DEF    = 300;
  localparam int SAMPLE_OFFSET_DEF = 150;

  // Raw state codes kept as plain constants so older blocks can keep comparing against them
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LATCH    = 3'd1;
  localparam logic [2:0] ST_BIT_LOW  = 3'd2;
  localparam logic [2:0] ST_BIT_HIGH = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_LATCH    = ST_LATCH,
    S_BIT_LOW  = ST_BIT_LOW,
    S_BIT_HIGH = ST_BIT_HIGH,
    S_DONE     = ST_DONE
  } pad_state_t;

endpackage

// File: rtl/pad_timing_gen.sv
// Frame sequencer: period counter plus latch / pulse waveform FSM shared by every pad.
// Latency: latch rises 1 cycle after a frame start; sample/frame strobes are decoded from registered state.
// Backpressure: none; i_poll_en only gates frame starts, a running frame always completes.
module pad_timing_gen
  import pad_pkg::*;
#(
  parameter int NUM_BUTTONS   = 8,
  parameter int POLL_PERIOD   = POLL_PERIOD_60HZ,
  parameter int LATCH_CYCLES  = LATCH_CYCLES_DEF,
  parameter int HALF_PULSE    = HALF_PULSE_DEF,
  parameter int SAMPLE_OFFSET = SAMPLE_OFFSET_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_poll_en,
  output logic o_latch,
  output logic o_pulse,
  output logic o_sample_strobe,
  output logic o_frame_done
);

  localparam int CW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int PMAX = (LATCH_CYCLES > HALF_PULSE) ? LATCH_CYCLES : HALF_PULSE;
  localparam int PW   = $clog2(PMAX) + 1;
  localparam int SW   = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(POLL_PERIOD - 1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYCLES - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PULSE - 1);
  localparam logic [PW-1:0] SAMPLE_AT  = PW'(SAMPLE_OFFSET);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_BUTTONS - 1);

  // A frame must end (back in IDLE) before the period counter can wrap to the next start
  generate
    if ((LATCH_CYCLES + 2 * HALF_PULSE * NUM_BUTTONS + 2 > POLL_PERIOD) ||
        (SAMPLE_OFFSET >= HALF_PULSE) || (NUM_BUTTONS < 2) || (LATCH_CYCLES < 1)) begin : g_bad_cfg
      $fatal(1, "pad_timing_gen: timing parameters do not fit inside the poll period");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_phase;
  logic [SW-1:0] r_slot;
  pad_state_t    r_state;
  logic          r_latch;
  logic          r_pulse;

  // Period counter: free-runs 0..POLL_PERIOD-1 while polling, parked at 0 otherwise
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (!i_poll_en || r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame FSM: latch phase, then NUM_BUTTONS low/high pulse slots, then a one-cycle DONE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_slot  <= '0;
      r_latch <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_poll_en && r_cnt == '0) begin
            r_state <= S_LATCH;
            r_phase <= '0;
            r_latch <= 1'b1;
          end
        end
        S_LATCH: begin
          if (r_phase == LATCH_LAST) begin
            r_state <= S_BIT_LOW;
            r_phase <= '0;
            r_slot  <= '0;
            r_latch <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_BIT_LOW: begin
          if (r_phase == HALF_LAST) begin
            r_state <= S_BIT_HIGH;
            r_phase <= '0;
            r_pulse <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_BIT_HIGH: begin
          if (r_phase == HALF_LAST) begin
            r_phase <= '0;
            r_pulse <= 1'b0;
            if (r_slot == SLOT_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_slot  <= r_slot + 1'b1;
              r_state <= S_BIT_LOW;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_latch <= 1'b0;
          r_pulse <= 1'b0;
        end
      endcase
    end
  end

  assign o_latch         = r_latch;
  assign o_pulse         = r_pulse;
  // Decoded from registered state only, so the consumer's registers land exactly on the named cycle
  assign o_sample_strobe = (r_state == S_BIT_LOW) && (r_phase == SAMPLE_AT);
  // Last cycle of the final high phase: the consumer's registers then update in the DONE cycle
  assign o_frame_done    = (r_state == S_BIT_HIGH) && (r_phase == HALF_LAST) && (r_slot == SLOT_LAST);

endmodule

// File: rtl/multi_pad_reader.sv
// Polls NUM_PADS serial game pads over a shared latch/pulse pair and publishes active-high button vectors.
// Latency: buttons/frame_valid update LATCH_CYCLES+2*HALF_PULSE*NUM_BUTTONS+1 cycles after a frame start.
// Backpressure: none; frame_valid is a one-cycle strobe. Optional edge outputs: PAD_EDGE_DETECT_EN.
module multi_pad_reader
  import pad_pkg::*;
#(
  parameter int NUM_PADS      = 2,
  parameter int NUM_BUTTONS   = 8,
  parameter int POLL_PERIOD   = POLL_PERIOD_60HZ,
  parameter int LATCH_CYCLES  = LATCH_CYCLES_DEF,
  parameter int HALF_PULSE    = HALF_PULSE_DEF,
  parameter int SAMPLE_OFFSET = SAMPLE_OFFSET_DEF
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            poll_en,
  input  logic [NUM_PADS-1:0]             data,
  output logic                            latch,
  output logic                            pulse,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] buttons,
  output logic                            frame_valid,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] pressed_edge,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] released_edge
);

  localparam int BW = NUM_PADS * NUM_BUTTONS;

  logic          w_sample;
  logic          w_frame_done;
  logic [BW-1:0] r_shift;
  logic [BW-1:0] r_buttons;
  logic          r_frame_valid;

  pad_timing_gen #(
    .NUM_BUTTONS  (NUM_BUTTONS),
    .POLL_PERIOD  (POLL_PERIOD),
    .LATCH_CYCLES (LATCH_CYCLES),
    .HALF_PULSE   (HALF_PULSE),
    .SAMPLE_OFFSET(SAMPLE_OFFSET)
  ) u_timing (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_poll_en      (poll_en),
    .o_latch        (latch),
    .o_pulse        (pulse),
    .o_sample_strobe(w_sample),
    .o_frame_done   (w_frame_done)
  );

  // Per-pad shift right: each sampled (inverted) bit enters at the MSB, so the first bit ends at bit 0
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift <= '0;
    end else if (w_sample) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        r_shift[p*NUM_BUTTONS +: NUM_BUTTONS] <=
          {~data[p], r_shift[p*NUM_BUTTONS+1 +: NUM_BUTTONS-1]};
      end
    end
  end

  // Publish the collected frame and raise the one-cycle strobe in the DONE cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_buttons     <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_frame_done;
      if (w_frame_done) begin
        r_buttons <= r_shift;
      end
    end
  end

  assign buttons     = r_buttons;
  assign frame_valid = r_frame_valid;

`ifdef PAD_EDGE_DETECT_EN
  logic [BW-1:0] r_pressed;
  logic [BW-1:0] r_released;

  // r_buttons still holds the previous frame when the new one loads, so it doubles as the history
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pressed  <= '0;
      r_released <= '0;
    end else if (w_frame_done) begin
      r_pressed  <= r_shift & ~r_buttons;
      r_released <= ~r_shift & r_buttons;
    end else begin
      r_pressed  <= '0;
      r_released <= '0;
    end
  end

  assign pressed_edge  = r_pressed;
  assign released_edge = r_released;
`else
  assign pressed_edge  = '0;
  assign released_edge = '0;
`endif

endmodule

// File: tb/tb_multi_pad_reader.sv
// Randomised bench for multi_pad_reader against a cycle-offset model of the frame timing.
// Latency: n/a.
// Backpressure: n/a.
module tb_multi_pad_reader;

  localparam int NP = 2;
  localparam int NB = 8;
  localparam int PP = 200;
  localparam int LC = 6;
  localparam int HP = 4;
  localparam int SO = 2;
  localparam int BW = NP * NB;
  localparam int BIT0   = LC + 1;             // first low phase, offset from frame start
  localparam int FV_OFF = LC + 2 * HP * NB + 1; // frame_valid offset
  localparam int BUSY   = FV_OFF + 1;         // first offset at which the poller is idle again

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          poll_en = 1'b0;
  logic [NP-1:0] data = '1;
  logic          latch;
  logic          pulse;
  logic [BW-1:0] buttons;
  logic          frame_valid;
  logic [BW-1:0] pressed_edge;
  logic [BW-1:0] released_edge;

  multi_pad_reader #(
    .NUM_PADS(NP), .NUM_BUTTONS(NB), .POLL_PERIOD(PP),
    .LATCH_CYCLES(LC), .HALF_PULSE(HP), .SAMPLE_OFFSET(SO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .poll_en(poll_en), .data(data),
    .latch(latch), .pulse(pulse), .buttons(buttons), .frame_valid(frame_valid),
    .pressed_edge(pressed_edge), .released_edge(released_edge)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            t_start = -100000;
  int            en_rise = 0;
  bit            en = 1'b0;
  bit            en_prev = 1'b0;
  bit            in_rst = 1'b1;
  logic [BW-1:0] cur_pat = '0;
  logic [BW-1:0] exp_btn = '0;
  logic [BW-1:0] pat_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: check this cycle's outputs against the model, then drive this cycle's inputs
  task automatic tick();
    int            o;
    logic          e_latch;
    logic          e_pulse;
    logic          e_fv;
    logic [BW-1:0] e_pe;
    logic [BW-1:0] e_re;
    logic [BW-1:0] old;
    @(posedge clk);
    cyc++;
    #1;
    o       = cyc - t_start;
    e_latch = !in_rst && (o >= 1) && (o <= LC);
    e_pulse = !in_rst && (o >= BIT0) && (o < FV_OFF) && ((((o - BIT0) / HP) % 2) == 1);
    e_fv    = !in_rst && (o == FV_OFF);
    e_pe    = '0;
    e_re    = '0;
    if (e_fv) begin
      old     = exp_btn;
      exp_btn = cur_pat;
`ifdef PAD_EDGE_DETECT_EN
      e_pe = exp_btn & ~old;
      e_re = ~exp_btn & old;
`endif
    end
    chk("latch",       64'(latch),         64'(e_latch));
    chk("pulse",       64'(pulse),         64'(e_pulse));
    chk("frame_valid", 64'(frame_valid),   64'(e_fv));
    chk("buttons",     64'(buttons),       64'(exp_btn));
    chk("pressed",     64'(pressed_edge),  64'(e_pe));
    chk("released",    64'(released_edge), 64'(e_re));

    poll_en = en;
    if (en && !en_prev) en_rise = cyc;
    en_prev = en;
    o = cyc - t_start;
    if (!in_rst && en && (((cyc - en_rise) % PP) == 0) && (o >= BUSY)) begin
      t_start = cyc;
      if (pat_q.size() > 0) cur_pat = pat_q.pop_front();
      else                  cur_pat = BW'($urandom);
    end
    o    = cyc - t_start;
    data = NP'($urandom);
    if ((o >= BIT0) && (o < FV_OFF) && (((o - BIT0) % (2 * HP)) == SO)) begin
      for (int p = 0; p < NP; p++) data[p] = ~cur_pat[p * NB + (o - BIT0) / (2 * HP)];
    end
  endtask

  task automatic wait_off(input int target);
    int n = 0;
    while (((cyc - t_start) != target) && (n < 1000)) begin
      tick();
      n++;
    end
    if ((cyc - t_start) != target) chk("wait_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    // Reset with polling off, then 500 idle cycles with no latch
    repeat (3) tick();
    chk("rst_latch",   64'(latch),       64'(0));
    chk("rst_pulse",   64'(pulse),       64'(0));
    chk("rst_buttons", 64'(buttons),     64'(0));
    chk("rst_fv",      64'(frame_valid), 64'(0));
    n_rst  = 1'b1;
    in_rst = 1'b0;
    repeat (500) tick();

    // Directed first frame, then the 01/03/00 edge sequence on pad0, then random frames
    pat_q.push_back(16'h005A);
    pat_q.push_back({8'($urandom), 8'h01});
    pat_q.push_back({8'($urandom), 8'h03});
    pat_q.push_back({8'($urandom), 8'h00});
    en = 1'b1;
    repeat (7 * PP + 10) tick();

    // Drop polling during slot 3: frame completes, then silence, then restart on raise
    wait_off(BIT0 + 3 * 2 * HP);
    en = 1'b0;
    repeat (450) tick();
    en = 1'b1;
    tick();
    chk("restart_start", 64'(cyc - t_start), 64'(0));
    repeat (PP + 80) tick();

    // Asynchronous reset during the high phase of slot 5 abandons the frame
    wait_off(BIT0 + 5 * 2 * HP + HP + 1);
    chk("pre_rst_pulse", 64'(pulse), 64'(1));
    #2;
    n_rst   = 1'b0;
    en      = 1'b0;
    poll_en = 1'b0;
    in_rst  = 1'b1;
    t_start = -100000;
    exp_btn = '0;
    #1;
    chk("arst_latch",   64'(latch),       64'(0));
    chk("arst_pulse",   64'(pulse),       64'(0));
    chk("arst_buttons", 64'(buttons),     64'(0));
    chk("arst_fv",      64'(frame_valid), 64'(0));
    repeat (3) tick();
    n_rst  = 1'b1;
    in_rst = 1'b0;
    repeat (100) tick();
    en = 1'b1;
    repeat (2 * PP + 80) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
